// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the 4-channel TDM demultiplexer.
// TDM_DEMUX_PARITY_EN appends an even-parity bit to every slot.
package tdm_demux_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  // Serial bits per slot, including the trailing parity bit when enabled.
  function automatic int slot_len(input int width);
`ifdef TDM_DEMUX_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/tdm_shift_in.sv
// MSB-first serial-to-parallel shifter with restart/clear and running parity.
// Honours TDM_DEMUX_PARITY_EN (trailing parity bit, mismatch flag).
module tdm_shift_in #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic             i_restart,
  input  logic             i_sd,
  output logic [WIDTH-1:0] o_word
`ifdef TDM_DEMUX_PARITY_EN
  ,
  output logic             o_par_err
`endif
);

`ifdef TDM_DEMUX_PARITY_EN
  localparam int SR_W = WIDTH;
`else
  // The final payload bit goes straight to the channel, so one less is stored.
  localparam int SR_W = WIDTH - 1;
`endif

  logic [SR_W-1:0] r_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= '0;
    end else if (i_clr) begin
      r_sr <= '0;
    end else if (i_shift) begin
      r_sr <= i_restart ? SR_W'(i_sd) : SR_W'({r_sr, i_sd});
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else if (i_clr) begin
      r_par <= 1'b0;
    end else if (i_shift) begin
      r_par <= i_restart ? i_sd : (r_par ^ i_sd);
    end
  end

  // Sampled while i_sd carries the parity bit; payload already sits in r_sr.
  assign o_word    = r_sr;
  assign o_par_err = r_par ^ i_sd;
`else
  assign o_word = {r_sr, i_sd};
`endif

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: frame-sync lock FSM, slot counters, channel registers.
// Optional TDM_DEMUX_PARITY_EN adds a per-slot even-parity bit and the perr pulse.
module tdm_demux4
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sd,
  input  logic             fs,
  output logic [WIDTH-1:0] ch0,
  output logic [WIDTH-1:0] ch1,
  output logic [WIDTH-1:0] ch2,
  output logic [WIDTH-1:0] ch3,
  output logic             v0,
  output logic             v1,
  output logic             v2,
  output logic             v3,
  output logic             sel1,
  output logic             sel0,
  output logic             locked,
  output logic             sync_err,
  output logic             perr
);

  localparam int              SLOT_LEN = slot_len(WIDTH);
  localparam int              CNT_W    = $clog2(SLOT_LEN);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SLOT_LEN - 1);

  state_t                 r_state;
  logic [CNT_W-1:0]       r_bit;
  logic [SLOT_W-1:0]      r_slot;
  logic [WIDTH-1:0]       r_ch [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   r_v;
  logic                   r_sync_err;
  logic [WIDTH-1:0]       w_word;
  logic                   w_frame_start;
  logic                   w_miss;
  logic                   w_shift;
  logic                   w_restart;
  logic [SLOT_W-1:0]      w_sel;

  // Slot 0 bit 0 in RUN only ever occurs at a frame boundary, where fs is mandatory.
  assign w_frame_start = (r_state == RUN) && (r_slot == '0) && (r_bit == '0);
  assign w_miss        = en && w_frame_start && !fs;
  assign w_shift       = en && (((r_state == HUNT) && fs) || ((r_state == RUN) && !w_miss));
  assign w_restart     = fs || (r_bit == '0);

`ifdef TDM_DEMUX_PARITY_EN
  logic w_par_err;
  logic r_perr;
`endif

  tdm_shift_in #(.WIDTH(WIDTH)) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_miss),
    .i_shift   (w_shift),
    .i_restart (w_restart),
    .i_sd      (sd),
    .o_word    (w_word)
`ifdef TDM_DEMUX_PARITY_EN
    ,
    .o_par_err (w_par_err)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= HUNT;
      r_bit      <= '0;
      r_slot     <= '0;
      r_v        <= '0;
      r_sync_err <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) r_ch[i] <= '0;
`ifdef TDM_DEMUX_PARITY_EN
      r_perr     <= 1'b0;
`endif
    end else begin
      r_v        <= '0;
      r_sync_err <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      r_perr     <= 1'b0;
`endif
      if (en) begin
        case (r_state)
          HUNT: begin
            if (fs) begin
              r_state <= RUN;
              r_bit   <= CNT_W'(1);
              r_slot  <= '0;
            end
          end
          RUN: begin
            if (w_miss) begin
              r_sync_err <= 1'b1;
              r_state    <= HUNT;
              r_bit      <= '0;
              r_slot     <= '0;
            end else if (fs) begin
              // Misplaced sync abandons the partial word and restarts the frame here.
              if (!w_frame_start) r_sync_err <= 1'b1;
              r_bit  <= CNT_W'(1);
              r_slot <= '0;
            end else if (r_bit == LAST_BIT) begin
              r_ch[r_slot] <= w_word;
              r_v[r_slot]  <= 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
              r_perr       <= w_par_err;
`endif
              r_bit        <= '0;
              r_slot       <= r_slot + 1'b1;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  assign w_sel          = (r_state == RUN) ? r_slot : '0;
  assign {sel1, sel0}   = w_sel;
  assign locked         = (r_state == RUN);
  assign sync_err       = r_sync_err;
  assign {v3, v2, v1, v0} = r_v;
  assign ch0            = r_ch[0];
  assign ch1            = r_ch[1];
  assign ch2            = r_ch[2];
  assign ch3            = r_ch[3];
`ifdef TDM_DEMUX_PARITY_EN
  assign perr           = r_perr;
`else
  assign perr           = 1'b0;
`endif

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-channel time-division demultiplexer: the receive-side counterpart of the team's 4:1 channel multiplexer. Accepts one serial TDM bit stream framed by a frame-sync pulse, splits each frame into four fixed-width slots, and presents each slot's word on a dedicated parallel channel output with a one-cycle valid strobe. Sits between the serial link input and the per-channel consumers.

## Interface
- WIDTH, 8, bits per channel slot (payload); legal range 2..32
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  bit-enable; sd/fs sampled only on clk edges with en=1
- sd  input  1  serial data, MSB of each slot first
- fs  input  1  frame sync; high with the first bit of slot 0
- ch0..ch3  output  WIDTH each  last completed word of slot 0..3
- v0..v3  output  1 each  one-cycle strobe: chN updated this cycle
- sel1, sel0  output  1 each  slot currently being received (binary {sel1,sel0})
- locked  output  1  high while in RUN
- sync_err  output  1  one-cycle pulse on framing fault
- perr  output  1  one-cycle pulse with vN on parity mismatch (see Configuration)

## Operation
- States: HUNT, RUN. Reset -> HUNT.
- Reset (asserted any time, incl. mid-word): chN=0, vN=0, sel=00, locked=0, sync_err=0, perr=0, bit/slot counters 0, shift register 0; partial word discarded.
- HUNT: sd ignored until qualified fs=1; that bit is bit 0 of slot 0, shifted in, state -> RUN, locked=1.
- RUN: each qualified sample shifts sd into shift register (MSB first), bit counter increments. Slot length L = WIDTH (WIDTH+1 with parity).
- Sample at bit L-1: chN <= {shift[WIDTH-2:0], sd} (payload bits), vN=1 next cycle for exactly one cycle, bit counter -> 0, slot counter increments mod 4 (wrap 3 -> 0).
- Frame boundary (first bit after slot 3): fs must be 1. If fs=0: sync_err pulse, bit discarded, -> HUNT, locked=0.
- fs=1 in RUN anywhere other than slot 0 bit 0: sync_err pulse, in-progress word discarded (no vN), this bit treated as slot 0 bit 0, stay RUN.
- sel1/sel0 reflect slot counter; 00 in HUNT.
- en=0: counters, shift register, state hold; strobes still drop after one cycle.
- At most one vN high per cycle.

## Timing
- Sampling edge of last slot bit -> chN and vN valid in following cycle (1-cycle latency from the final sample edge).
- sync_err and perr are registered, coincident with the cycle after the offending sample.
- chN holds value until next completion of slot N; no handshake, consumer must capture on vN.
- Back-to-back: with en=1 continuously, v0..v3 assert every WIDTH (or WIDTH+1) cycles in order 0,1,2,3.

## Configuration
- TDM_DEMUX_PARITY_EN defined: each slot is WIDTH+1 bits; final bit is even parity over the WIDTH payload bits. chN still updated on mismatch; perr pulses with that vN.
- Undefined: slot is WIDTH bits; perr tied 0.

## Structure
- Package tdm_demux_pkg: state enum (HUNT, RUN), NUM_SLOTS=4, slot index width 2.
- One sub-module: tdm_shift_in (WIDTH-bit MSB-first shift register with enable, clear, and running parity), instantiated once; top holds FSM, counters, channel registers.

## Test plan
- Reset mid-slot: stream frame with WIDTH=8, assert rst_n=0 during slot 2 bit 4 -> all outputs 0, locked=0, no vN; next fs relocks.
- Clean frame: fs with slot words A5, 3C, 0F, F0, en=1 continuous -> ch0=A5..ch3=F0, v0..v3 pulses 8 cycles apart, one cycle wide.
- en gaps: same frame with en=1 every other cycle -> identical channel values, strobes 16 cycles apart.
- Early fs: fs at slot 1 bit 3 -> sync_err pulse, no v1, next 8 bits land in ch0, locked stays 1.
- Missing fs at frame boundary -> sync_err pulse, locked=0, sel=00, no further vN until fs.
- Parity (TDM_DEMUX_PARITY_EN): slot 0 word 81 with parity bit 1 -> v0 with perr=1, ch0=81; parity bit 0 -> perr=0.
